uart_rx: RTL and testbench

//   Serial receiver for the board COM port (com_RxD line), 8N1, LSB first.

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side and serial-line signals of the 8N1 receiver.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rx_if;
   logic       rxd;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       clr_err_i;
   logic       busy_o;

   modport slave (
      input  rxd,
      input  ready_i,
      input  clr_err_i,
      output data_o,
      output valid_o,
      output frame_err_o,
      output overrun_o,
      output busy_o
   );

   modport master (
      output rxd,
      output ready_i,
      output clr_err_i,
      input  data_o,
      input  valid_o,
      input  frame_err_o,
      input  overrun_o,
      input  busy_o
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronised, mid-bit sampled, LSB first, with a
// one-entry valid/ready holding register and sticky frame/overrun flags.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 8) begin : g_bad_param
      $error("uart_rx: CLKS_PER_BIT must be >= 8");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shreg;
   logic [7:0]         r_data;
   logic               r_valid;
   logic               r_ferr;
   logic               r_ovr;
   logic               r_busy;
   logic               r_sync1;
   logic               r_sync2;

   logic               w_rxd_s;
   logic               w_half_tick;
   logic               w_bit_tick;
   logic               w_accept;

   assign w_rxd_s     = r_sync2;
   assign w_half_tick = (r_cnt == CNT_W'(HALF_BIT - 1));
   assign w_bit_tick  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_accept    = r_valid && bus.ready_i;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b0;
         end
         // Clear comes first so a same-cycle set event below wins.
         if (bus.clr_err_i) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (!w_rxd_s) begin
                  r_state <= S_START;
                  r_busy  <= 1'b1;
               end
            end

            S_START: begin
               if (w_half_tick) begin
                  r_cnt <= '0;
                  if (w_rxd_s) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (w_bit_tick) begin
                  r_cnt     <= '0;
                  r_shreg   <= {w_rxd_s, r_shreg[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (w_bit_tick) begin
                  r_cnt <= '0;
                  if (w_rxd_s) begin
                     // A consumer taking the old byte this cycle frees the slot.
                     if (!r_valid || w_accept) begin
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_BREAK: begin
               r_cnt <= '0;
               if (w_rxd_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_o      = r_data;
   assign bus.valid_o     = r_valid;
   assign bus.frame_err_o = r_ferr;
   assign bus.overrun_o   = r_ovr;
   assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model (deliveries, errors, busy windows
// scheduled from the serial timing) checked every cycle, plus directed literal checks.
module tb_uart_rx;

   localparam int unsigned CPB  = 16;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned LAT  = 3 + HALF + 9 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_if bus();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {EV_ON, EV_OFF, EV_DLV, EV_FERR} ev_kind_t;
   typedef struct {
      int unsigned cyc;
      ev_kind_t    kind;
      logic [7:0]  b;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] rx_log[$];

   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   bit         m_ferr  = 1'b0;
   bit         m_ovr   = 1'b0;
   bit         m_busy  = 1'b0;
   bit         p_ready = 1'b0;
   bit         p_clr   = 1'b0;
   bit         p_rst   = 1'b0;
   bit         checking = 1'b0;
   bit         rand_mode = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void push(input int unsigned c, input ev_kind_t k, input logic [7:0] b);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.b    = b;
      evq.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: each edge applies last cycle's handshake/clear, then the events due now.
   always @(negedge clk) begin
      bit hs;
      bit dlv;
      if (p_rst) begin
         m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
         evq.delete();
         checking = 1'b1;
      end else if (checking) begin
         hs  = m_valid && p_ready;
         dlv = 1'b0;
         if (p_clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
         end
         for (int i = int'(evq.size()) - 1; i >= 0; i--) begin
            if (evq[i].cyc == cyc) begin
               case (evq[i].kind)
                  EV_ON:   m_busy = 1'b1;
                  EV_OFF:  m_busy = 1'b0;
                  EV_FERR: m_ferr = 1'b1;
                  EV_DLV: begin
                     if (!m_valid || hs) begin
                        m_data  = evq[i].b;
                        m_valid = 1'b1;
                        dlv     = 1'b1;
                     end else begin
                        m_ovr = 1'b1;
                     end
                  end
                  default: ;
               endcase
               evq.delete(i);
            end
         end
         if (hs && !dlv) m_valid = 1'b0;
      end
      if (checking) begin
         n_tests++;
         if ({bus.data_o, bus.valid_o, bus.frame_err_o, bus.overrun_o, bus.busy_o} !==
             {m_data, m_valid, m_ferr, m_ovr, m_busy}) begin
            n_fail++;
            $display("FAIL cycle %0d: got data=%h v=%b fe=%b ov=%b busy=%b, expected data=%h v=%b fe=%b ov=%b busy=%b",
                     cyc, bus.data_o, bus.valid_o, bus.frame_err_o, bus.overrun_o, bus.busy_o,
                     m_data, m_valid, m_ferr, m_ovr, m_busy);
         end
         if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) rx_log.push_back(bus.data_o);
      end
      p_ready = bus.ready_i;
      p_clr   = bus.clr_err_i;
      p_rst   = rst;
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         bus.ready_i   = 1'($urandom_range(0, 1));
         bus.clr_err_i = ($urandom_range(0, 15) == 0);
      end
   end

   // Start bit falls right after edge t0; stop sample lands on edge t0+LAT.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned brk);
      int unsigned t0;
      tick();
      bus.rxd = 1'b0;
      t0 = cyc;
      push(t0 + 3, EV_ON, 8'h00);
      if (stop_ok) begin
         push(t0 + LAT, EV_DLV, b);
         push(t0 + LAT, EV_OFF, 8'h00);
      end else begin
         push(t0 + LAT, EV_FERR, 8'h00);
      end
      repeat (CPB - 1) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.rxd = b[i];
         repeat (CPB - 1) tick();
      end
      tick();
      bus.rxd = stop_ok;
      repeat (CPB - 1) tick();
      if (!stop_ok) begin
         repeat (brk) tick();
         tick();
         bus.rxd = 1'b1;
         push(cyc + 3, EV_OFF, 8'h00);
         repeat (CPB) tick();
      end
   endtask

   task automatic glitch();
      int unsigned t0;
      tick();
      bus.rxd = 1'b0;
      t0 = cyc;
      push(t0 + 3, EV_ON, 8'h00);
      push(t0 + 3 + HALF, EV_OFF, 8'h00);
      repeat (3) tick();
      tick();
      bus.rxd = 1'b1;
      repeat (2 * CPB) tick();
   endtask

   initial begin
      int unsigned sz;
      int unsigned t0;
      bus.rxd       = 1'b1;
      bus.ready_i   = 1'b0;
      bus.clr_err_i = 1'b0;

      repeat (3) tick();
      chk("reset_data",  bus.data_o, 0);
      chk("reset_valid", bus.valid_o, 0);
      chk("reset_ferr",  bus.frame_err_o, 0);
      chk("reset_ovr",   bus.overrun_o, 0);
      chk("reset_busy",  bus.busy_o, 0);
      rst = 1'b0;
      repeat (5) tick();

      // 1: single byte
      bus.ready_i = 1'b1;
      sz = rx_log.size();
      send_frame(8'h55, 1'b1, 0);
      repeat (4) tick();
      chk("t1_count", rx_log.size() - sz, 1);
      if (rx_log.size() > 0) chk("t1_byte", rx_log[rx_log.size() - 1], 8'h55);
      chk("t1_data", bus.data_o, 8'h55);
      chk("t1_flags", {bus.frame_err_o, bus.overrun_o}, 0);

      // 2: short glitch
      sz = rx_log.size();
      glitch();
      chk("t2_count", rx_log.size() - sz, 0);
      chk("t2_state", {bus.valid_o, bus.frame_err_o, bus.overrun_o, bus.busy_o}, 0);

      // 3: framing error, break, recovery, clear
      send_frame(8'hA5, 1'b0, 100);
      chk("t3_ferr", bus.frame_err_o, 1);
      chk("t3_valid", bus.valid_o, 0);
      send_frame(8'h3C, 1'b1, 0);
      repeat (4) tick();
      chk("t3_data", bus.data_o, 8'h3C);
      bus.clr_err_i = 1'b1;
      tick();
      bus.clr_err_i = 1'b0;
      tick();
      chk("t3_clr", bus.frame_err_o, 0);

      // 4: overrun with stalled consumer
      bus.ready_i = 1'b0;
      send_frame(8'hA5, 1'b1, 0);
      send_frame(8'h0F, 1'b1, 0);
      repeat (5) tick();
      chk("t4_data", bus.data_o, 8'hA5);
      chk("t4_valid", bus.valid_o, 1);
      chk("t4_ovr", bus.overrun_o, 1);
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      tick();
      chk("t4_drain", bus.valid_o, 0);
      bus.clr_err_i = 1'b1;
      tick();
      bus.clr_err_i = 1'b0;
      tick();
      chk("t4_clr", bus.overrun_o, 0);

      // 5: reset mid-frame
      bus.ready_i = 1'b1;
      tick();
      bus.rxd = 1'b0;
      t0 = cyc;
      push(t0 + 3, EV_ON, 8'h00);
      repeat (CPB - 1) tick();
      tick();
      bus.rxd = 1'b1;
      repeat (2 * CPB) tick();
      chk("t5_busy", bus.busy_o, 1);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (12 * CPB) tick();
      sz = rx_log.size();
      send_frame(8'h81, 1'b1, 0);
      repeat (4) tick();
      chk("t5_count", rx_log.size() - sz, 1);
      if (rx_log.size() > 0) chk("t5_byte", rx_log[rx_log.size() - 1], 8'h81);

      // 6: back-to-back frames
      sz = rx_log.size();
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h7E, 1'b1, 0);
      repeat (4) tick();
      chk("t6_count", rx_log.size() - sz, 3);
      if (rx_log.size() >= sz + 3) begin
         chk("t6_b0", rx_log[sz],     8'h00);
         chk("t6_b1", rx_log[sz + 1], 8'hFF);
         chk("t6_b2", rx_log[sz + 2], 8'h7E);
      end
      chk("t6_flags", {bus.frame_err_o, bus.overrun_o}, 0);

      // Randomised traffic against the model
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 20)) tick();
         if ($urandom_range(0, 9) == 0) glitch();
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(0, 40));
      end
      rand_mode = 1'b0;
      tick();
      bus.ready_i   = 1'b1;
      bus.clr_err_i = 1'b0;
      repeat (LAT) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
